// File: rtl/mux_scan_reg.sv
// Registered N:1 channel router with manual-select and auto-scan modes.
// The output is a valid/ready stage; a held sample is never dropped or overwritten.
module mux_scan_reg #(
   parameter int width   = 4,
   parameter int swidth  = 4,
   parameter int dwell_w = 8
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [width*(2**swidth)-1:0]    i,
   input  logic [swidth-1:0]               sel,
   input  logic                            mode,
   input  logic                            en,
   input  logic [dwell_w-1:0]              dwell,
   output logic [width-1:0]                o,
   output logic [swidth-1:0]               o_ch,
   output logic                            o_valid,
   input  logic                            o_ready
);

   typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

   state_t               state_q, state_d;
   logic [swidth-1:0]    ch_q, ch_d;
   logic [dwell_w-1:0]   dcnt_q, dcnt_d;
   logic [width-1:0]     o_q, o_d;
   logic [swidth-1:0]    o_ch_q, o_ch_d;
   logic                 o_valid_q, o_valid_d;
   logic                 load;
   logic [swidth-1:0]    cs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         dcnt_q    <= '0;
         o_q       <= '0;
         o_ch_q    <= '0;
         o_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         dcnt_q    <= dcnt_d;
         o_q       <= o_d;
         o_ch_q    <= o_ch_d;
         o_valid_q <= o_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (en) state_d = mode ? SCAN : MANUAL;
         end
         MANUAL: begin
            if (!en)      state_d = IDLE;
            else if (mode) state_d = SCAN;
         end
         SCAN: begin
            if (!en)       state_d = IDLE;
            else if (!mode) state_d = MANUAL;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load      = (state_q != IDLE) && (!o_valid_q || o_ready);
      cs        = (state_q == MANUAL) ? sel : ch_q;
      o_d       = o_q;
      o_ch_d    = o_ch_q;
      o_valid_d = o_valid_q;
      ch_d      = ch_q;
      dcnt_d    = dcnt_q;

      if (load) begin
         o_d       = i[32'(cs)*width +: width];
         o_ch_d    = cs;
         o_valid_d = 1'b1;
         // >= so that lowering dwell below the running count forces an advance
         if (state_q == SCAN) begin
            if (dcnt_q >= dwell) begin
               ch_d   = ch_q + swidth'(1);
               dcnt_d = '0;
            end else begin
               dcnt_d = dcnt_q + dwell_w'(1);
            end
         end
      end else if (state_q == IDLE && o_ready) begin
         o_valid_d = 1'b0;
      end

      // Entering scan always restarts from channel 0
      if (state_d == SCAN && state_q != SCAN) begin
         ch_d   = '0;
         dcnt_d = '0;
      end
   end

   assign o       = o_q;
   assign o_ch    = o_ch_q;
   assign o_valid = o_valid_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: directed scenarios plus random traffic, all checked
// against a channel/dwell reference model kept in the bench.
module tb_mux_scan_reg;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] i;
   logic [3:0]  sel;
   logic        mode;
   logic        en;
   logic [7:0]  dwell;
   logic [3:0]  o;
   logic [3:0]  o_ch;
   logic        o_valid;
   logic        o_ready;

   int errors = 0;
   int checks = 0;

   // reference model: 0 = idle, 1 = manual, 2 = scan
   int m_state, m_ch, m_dcnt, m_o, m_och, m_v;

   mux_scan_reg #(.width(4), .swidth(4), .dwell_w(8)) dut (
      .clk(clk), .reset_n(reset_n), .i(i), .sel(sel), .mode(mode), .en(en),
      .dwell(dwell), .o(o), .o_ch(o_ch), .o_valid(o_valid), .o_ready(o_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_ch = 0; m_dcnt = 0; m_o = 0; m_och = 0; m_v = 0;
   endtask

   task automatic model_step();
      int cs;
      bit accept;
      accept = (m_state != 0) && (m_v == 0 || o_ready);
      if (accept) begin
         cs    = (m_state == 1) ? int'(sel) : m_ch;
         m_o   = int'((i >> (cs * 4)) & 64'hF);
         m_och = cs;
         m_v   = 1;
         if (m_state == 2) begin
            if (m_dcnt >= int'(dwell)) begin
               m_ch   = (m_ch + 1) % 16;
               m_dcnt = 0;
            end else begin
               m_dcnt = m_dcnt + 1;
            end
         end
      end else if (m_state == 0 && o_ready) begin
         m_v = 0;
      end
      case (m_state)
         0: if (en) begin
               if (mode) begin m_state = 2; m_ch = 0; m_dcnt = 0; end
               else m_state = 1;
            end
         1: if (!en) m_state = 0;
            else if (mode) begin m_state = 2; m_ch = 0; m_dcnt = 0; end
         default: if (!en) m_state = 0;
            else if (!mode) m_state = 1;
      endcase
   endtask

   task automatic cyc(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk({tag, ".o"}, 32'(o), 32'(m_o));
      chk({tag, ".o_ch"}, 32'(o_ch), 32'(m_och));
      chk({tag, ".o_valid"}, 32'(o_valid), 32'(m_v));
   endtask

   initial begin
      reset_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; dwell = '0;
      o_ready = 1'b1; i = 64'hFEDC_BA98_7654_3210;
      model_reset();
      #2;
      chk("rst.o", 32'(o), 0);
      chk("rst.o_valid", 32'(o_valid), 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc("idle");
         chk("idle.const_valid", 32'(o_valid), 0);
         chk("idle.const_o", 32'(o), 0);
      end

      // manual walk
      en = 1'b1; mode = 1'b0;
      cyc("man_enter");
      for (int s = 0; s < 16; s++) begin
         sel = 4'(s);
         cyc("man");
         chk("man.o_eq_sel", 32'(o), 32'(s));
         chk("man.och_eq_sel", 32'(o_ch), 32'(s));
         chk("man.valid", 32'(o_valid), 1);
      end

      // scan with dwell=2, including wrap
      mode = 1'b1; dwell = 8'd2;
      cyc("scan_enter");
      for (int k = 0; k < 49; k++) begin
         cyc("scan");
         chk("scan.seq", 32'(o), 32'((k / 3) % 16));
         chk("scan.och", 32'(o_ch), 32'((k / 3) % 16));
      end

      // backpressure in scan, dwell=0
      mode = 1'b0; dwell = 8'd0;
      cyc("bp_man");
      mode = 1'b1;
      cyc("bp_rescan");
      for (int k = 0; k < 4; k++) begin
         cyc("bp_run");
         chk("bp_run.seq", 32'(o), 32'(k));
      end
      o_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc("bp_stall");
         chk("bp_stall.o", 32'(o), 3);
         chk("bp_stall.och", 32'(o_ch), 3);
         chk("bp_stall.valid", 32'(o_valid), 1);
      end
      o_ready = 1'b1;
      cyc("bp_rel1");
      chk("bp_rel.next4", 32'(o), 4);
      cyc("bp_rel2");
      chk("bp_rel.next5", 32'(o), 5);

      // en falls during a stall: sample drains, no new loads
      o_ready = 1'b0;
      cyc("drain_stall");
      en = 1'b0;
      cyc("drain_en_fall");
      chk("drain.held_valid", 32'(o_valid), 1);
      chk("drain.held_o", 32'(o), 5);
      cyc("drain_idle_stall");
      chk("drain.still_valid", 32'(o_valid), 1);
      o_ready = 1'b1;
      cyc("drain_accept");
      chk("drain.cleared", 32'(o_valid), 0);
      for (int k = 0; k < 3; k++) begin
         i = {$urandom, $urandom};
         cyc("drain_quiet");
         chk("drain.no_load_o", 32'(o), 5);
      end

      // async reset mid-scan at channel 9
      i = 64'hFEDC_BA98_7654_3210;
      en = 1'b1; mode = 1'b1; dwell = 8'd0;
      cyc("ar_enter");
      for (int k = 0; k < 10; k++) begin
         cyc("ar_scan");
         chk("ar_scan.seq", 32'(o), 32'(k));
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar.o_now", 32'(o), 0);
      chk("ar.och_now", 32'(o_ch), 0);
      chk("ar.valid_now", 32'(o_valid), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cyc("ar_restart_enter");
      cyc("ar_restart0");
      chk("ar.restart_ch0", 32'(o_ch), 0);
      cyc("ar_restart1");
      chk("ar.restart_ch1", 32'(o_ch), 1);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         i       = {$urandom, $urandom};
         sel     = 4'($urandom);
         o_ready = ($urandom % 3) != 0;
         if ($urandom % 12 == 0) mode = ~mode;
         en      = ($urandom % 20) != 0;
         if ($urandom % 25 == 0) dwell = 8'($urandom % 4);
         cyc("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
